// File: rtl/poly_tone_synth_if.sv
// Voice control and sample handshake bundle between the key decode logic and poly_tone_synth.
interface poly_tone_synth_if #(
    parameter int NUM_VOICES = 10,
    parameter int PHASE_W    = 32,
    parameter int SAMPLE_W   = 32
);
    logic [NUM_VOICES-1:0]         key_on;
    logic [NUM_VOICES*PHASE_W-1:0] tune_words;
    logic                          sample_req;
    logic                          sample_ready;
    logic signed [SAMPLE_W-1:0]    sample_out;
    logic                          sample_valid;
    logic                          busy;
    logic [4:0]                    active_voices;

    modport master (
        output key_on, tune_words, sample_req, sample_ready,
        input  sample_out, sample_valid, busy, active_voices
    );
    modport slave (
        input  key_on, tune_words, sample_req, sample_ready,
        output sample_out, sample_valid, busy, active_voices
    );
endinterface

// File: rtl/poly_tone_synth.sv
// Polyphonic phase-accumulator synth: voices share one sine ROM, time-multiplexed per sample request.
// The sine ROM is built at elaboration from a quarter-wave polynomial, so it needs no init file.
module poly_tone_synth #(
    parameter int NUM_VOICES   = 10,
    parameter int PHASE_W      = 32,
    parameter int LUT_ADDR_W   = 10,
    parameter int LUT_W        = 16,
    parameter int SAMPLE_W     = 32,
    parameter int ATTACK_STEP  = 16,
    parameter int RELEASE_STEP = 4,
    parameter int MIX_SHIFT    = 2
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    poly_tone_synth_if.slave bus
);
    localparam int LUT_DEPTH = 2 ** LUT_ADDR_W;
    localparam int QTR_W     = LUT_ADDR_W - 32'sd2;
    localparam int ACC_W     = LUT_W + 32'sd9 + $clog2(NUM_VOICES);
    localparam int MIX_W     = LUT_W + 32'sd8;
    localparam int VIDX_W    = (NUM_VOICES > 32'sd1) ? $clog2(NUM_VOICES) : 32'sd1;
    localparam logic [4:0] LAST_CNT = 5'(NUM_VOICES + 32'sd1);
    localparam logic signed [ACC_W-1:0] MIX_MAX = ACC_W'({1'b0, {(MIX_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] MIX_MIN = ~MIX_MAX;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, HOLD = 2'd3} state_t;

    // sin(pi/2*x) ~ x*(A - B*x^2 + C*x^4) in Q16; A-B+C = 1 so full scale is exact.
    function automatic logic signed [LUT_W-1:0] sine_entry(input int idx);
        logic [1:0] quad;
        logic       neg;
        longint     amp, off, pos, xf, x2, inner, mag;
        amp  = (64'sd1 <<< (LUT_W - 32'sd1)) - 64'sd1;
        quad = 2'(idx >>> QTR_W);
        off  = longint'(idx) & ((64'sd1 <<< QTR_W) - 64'sd1);
        case (quad)
            2'd0:    begin pos = off;                           neg = 1'b0; end
            2'd1:    begin pos = (64'sd1 <<< QTR_W) - off;      neg = 1'b0; end
            2'd2:    begin pos = off;                           neg = 1'b1; end
            2'd3:    begin pos = (64'sd1 <<< QTR_W) - off;      neg = 1'b1; end
            default: begin pos = 64'sd0;                        neg = 1'b0; end
        endcase
        xf    = (pos <<< 16) >>> QTR_W;
        x2    = (xf * xf) >>> 16;
        inner = 64'sd102944 - ((64'sd42047 * x2) >>> 16) + ((((64'sd4639 * x2) >>> 16) * x2) >>> 16);
        mag   = (amp * ((xf * inner) >>> 16)) >>> 16;
        if (mag > amp) begin
            mag = amp;
        end else begin
            mag = mag;
        end
        return neg ? LUT_W'(-mag) : LUT_W'(mag);
    endfunction

    logic signed [LUT_W-1:0]    lut_rom_s [LUT_DEPTH];
    state_t                     state_r, state_s;
    logic [4:0]                 cnt_r;
    logic [PHASE_W-1:0]         phase_r [NUM_VOICES];
    logic [7:0]                 gain_r  [NUM_VOICES];
    logic [7:0]                 gain_pipe_r;
    logic signed [LUT_W-1:0]    lut_q_r;
    logic signed [ACC_W-1:0]    acc_r;
    logic signed [SAMPLE_W-1:0] sample_out_r;
    logic                       sample_valid_r, busy_r;
    logic [4:0]                 active_r, active_s;
    logic                       rd_en_s, acc_en_s;
    logic [VIDX_W-1:0]          rd_idx_s;
    logic [PHASE_W-1:0]         cur_phase_s, next_phase_s, tune_s;
    logic [7:0]                 cur_gain_s, next_gain_s;
    logic [8:0]                 gain_up_s;
    logic [LUT_ADDR_W-1:0]      lut_addr_s;
    logic signed [LUT_W+8:0]    prod_s;
    logic signed [ACC_W-1:0]    mix_s;
    logic signed [MIX_W-1:0]    sat_s;

    for (genvar i = 0; i < LUT_DEPTH; i++) begin : g_rom
        assign lut_rom_s[i] = sine_entry(i);
    end

    assign rd_en_s  = (state_r == RUN) && (cnt_r != 5'd0) && (cnt_r <= 5'(NUM_VOICES));
    assign acc_en_s = (state_r == RUN) && (cnt_r >= 5'd2);
    assign rd_idx_s = rd_en_s ? VIDX_W'(cnt_r - 5'd1) : {VIDX_W{1'b0}};
    assign prod_s   = lut_q_r * $signed({1'b0, gain_pipe_r});

    // Next-state logic of the request sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (bus.sample_req)    state_s = RUN;  else state_s = IDLE;
            RUN:     if (cnt_r == LAST_CNT) state_s = DONE; else state_s = RUN;
            DONE:    state_s = HOLD;
            HOLD:    if (bus.sample_ready)  state_s = IDLE; else state_s = HOLD;
            default: state_s = IDLE;
        endcase
    end

    // Envelope and phase step for the voice read this cycle; a silent released voice is parked at phase 0.
    always_comb begin
        cur_phase_s  = phase_r[rd_idx_s];
        cur_gain_s   = gain_r[rd_idx_s];
        tune_s       = bus.tune_words[rd_idx_s*PHASE_W +: PHASE_W];
        lut_addr_s   = cur_phase_s[PHASE_W-1 -: LUT_ADDR_W];
        gain_up_s    = {1'b0, cur_gain_s} + 9'(ATTACK_STEP);
        next_phase_s = cur_phase_s + tune_s;
        next_gain_s  = cur_gain_s;
        if (bus.key_on[rd_idx_s]) begin
            next_gain_s = gain_up_s[8] ? 8'd255 : gain_up_s[7:0];
        end else if (cur_gain_s == 8'd0) begin
            next_phase_s = {PHASE_W{1'b0}};
            next_gain_s  = 8'd0;
        end else if (cur_gain_s <= 8'(RELEASE_STEP)) begin
            next_gain_s = 8'd0;
        end else begin
            next_gain_s = cur_gain_s - 8'(RELEASE_STEP);
        end
    end

    // Mix scaling, saturation and live-voice count.
    always_comb begin
        mix_s = acc_r >>> MIX_SHIFT;
        if (mix_s > MIX_MAX) begin
            sat_s = MIX_W'(MIX_MAX);
        end else if (mix_s < MIX_MIN) begin
            sat_s = MIX_W'(MIX_MIN);
        end else begin
            sat_s = MIX_W'(mix_s);
        end
        active_s = 5'd0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (gain_r[v] != 8'd0) active_s = active_s + 5'd1;
            else                   active_s = active_s;
        end
    end

    // Sequencer state and per-sample cycle counter.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
            cnt_r   <= 5'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= (state_r == RUN) ? cnt_r + 5'd1 : 5'd0;
        end
    end

    // Per-voice phase and gain registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase_r[v] <= {PHASE_W{1'b0}};
                gain_r[v]  <= 8'd0;
            end
        end else if (rd_en_s) begin
            phase_r[rd_idx_s] <= next_phase_s;
            gain_r[rd_idx_s]  <= next_gain_s;
        end
    end

    // ROM read pipeline and accumulator.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            lut_q_r     <= {LUT_W{1'b0}};
            gain_pipe_r <= 8'd0;
            acc_r       <= {ACC_W{1'b0}};
        end else begin
            if (rd_en_s) begin
                lut_q_r     <= lut_rom_s[lut_addr_s];
                gain_pipe_r <= cur_gain_s;
            end
            if ((state_r == IDLE) && bus.sample_req) acc_r <= {ACC_W{1'b0}};
            else if (acc_en_s)                       acc_r <= acc_r + ACC_W'(prod_s);
        end
    end

    // Registered outputs; sample_out keeps its value after the handshake.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sample_out_r   <= {SAMPLE_W{1'b0}};
            sample_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            active_r       <= 5'd0;
        end else begin
            sample_valid_r <= (state_s == HOLD);
            busy_r         <= (state_s != IDLE);
            if (state_r == DONE) begin
                sample_out_r <= SAMPLE_W'(sat_s) <<< (SAMPLE_W - MIX_W);
                active_r     <= active_s;
            end
        end
    end

    assign bus.sample_out    = sample_out_r;
    assign bus.sample_valid  = sample_valid_r;
    assign bus.busy          = busy_r;
    assign bus.active_voices = active_r;
endmodule

// File: tb/tb_poly_tone_synth.sv
// Directed scoreboard bench for poly_tone_synth: expected samples are queued at request, checked at handshake.
module tb_poly_tone_synth;
    localparam int NV = 10;
    localparam int PW = 32;
    localparam int SW = 32;
    localparam longint AMP = 64'sd32767;

    typedef struct packed {
        logic [31:0] out;
        logic [4:0]  act;
        logic [15:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    poly_tone_synth_if #(.NUM_VOICES(NV), .PHASE_W(PW), .SAMPLE_W(SW)) bus ();

    poly_tone_synth #(
        .NUM_VOICES(NV), .PHASE_W(PW), .LUT_ADDR_W(10), .LUT_W(16), .SAMPLE_W(SW),
        .ATTACK_STEP(16), .RELEASE_STEP(4), .MIX_SHIFT(2)
    ) dut (
        .CLOCK_50(clk),
        .resetn  (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Mixer model: arithmetic >>>2, clamp to signed 24 bits, left-justify in 32 bits.
    function automatic logic [31:0] mix_out(input longint acc);
        longint m;
        m = acc >>> 2;
        if (m > 64'sd8388607) m = 64'sd8388607;
        else if (m < -64'sd8388608) m = -64'sd8388608;
        return 32'(m <<< 8);
    endfunction

    task automatic set_tune(input int v, input logic [PW-1:0] val);
        bus.tune_words[v*PW +: PW] = val;
    endtask

    task automatic set_all_tunes(input logic [PW-1:0] val);
        for (int v = 0; v < NV; v++) bus.tune_words[v*PW +: PW] = val;
    endtask

    // One request/response with sample_ready held high; optionally checks latency and ignored re-request.
    task automatic do_sample(input logic [31:0] e_out, input logic [4:0] e_act,
                             input int tag, input bit check_lat);
        exp_t e;
        int   n;
        int   extra;
        bit   seen;
        e.out = e_out; e.act = e_act; e.tag = 16'(tag);
        exp_q.push_back(e);
        @(negedge clk); bus.sample_req = 1'b1;
        @(negedge clk); bus.sample_req = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (check_lat && n == 5) bus.sample_req = 1'b1;
            if (n == 6) bus.sample_req = 1'b0;
            seen = bus.sample_valid;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL timeout_sample%0d: got no sample_valid expected one within 40 cycles", tag);
        end
        if (check_lat) check32("latency", 32'(n), 32'd13);
        @(posedge clk); #1;
        check32("valid_drop", 32'(bus.sample_valid), 32'd0);
        check32("busy_drop", 32'(bus.busy), 32'd0);
        if (check_lat) begin
            extra = 0;
            repeat (20) begin
                @(posedge clk); #1;
                if (bus.sample_valid) extra++;
            end
            check32("ignored_req", 32'(extra), 32'd0);
        end
    endtask

    // Monitor: compare each accepted sample against the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.sample_valid && bus.sample_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_sample: got %h expected none", bus.sample_out);
            end else begin
                e = exp_q.pop_front();
                check32($sformatf("sample%0d_out", e.tag), bus.sample_out, e.out);
                check32($sformatf("sample%0d_active", e.tag), 32'(bus.active_voices), 32'(e.act));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int     g, g0, go;
        int     n;
        bit     seen;
        logic [31:0] held;
        rst_n = 1'b0;
        bus.key_on = '0;
        bus.tune_words = '0;
        bus.sample_req = 1'b0;
        bus.sample_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_out", bus.sample_out, 32'h0);
        check32("rst_valid", 32'(bus.sample_valid), 32'd0);
        check32("rst_busy", 32'(bus.busy), 32'd0);
        check32("rst_active", 32'(bus.active_voices), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // All voices silent; latency and ignored second request.
        do_sample(32'h0, 5'd0, 1, 1'b1);

        // Attack: first sample moves voice 0 to table index 256, then parks it there.
        bus.key_on[0] = 1'b1;
        set_tune(0, 32'h4000_0000);
        do_sample(32'h0, 5'd1, 10, 1'b0);
        set_tune(0, 32'h0);
        for (int k = 1; k <= 17; k++) begin
            g = (k < 16) ? 16 * k : 255;
            do_sample((g == 255) ? 32'h1FDF_C000 : mix_out(AMP * g), 5'd1, 10 + k, 1'b0);
        end

        // Release: 255 down by 4 reaches 0 after 64 samples.
        bus.key_on[0] = 1'b0;
        for (int j = 0; j < 64; j++) begin
            g = 255 - 4 * j;
            do_sample(mix_out(AMP * g), (j < 63) ? 5'd1 : 5'd0, 100 + j, 1'b0);
        end
        do_sample(32'h0, 5'd0, 164, 1'b0);

        // Retrigger must start from table index 0 (LUT 0), not 256.
        bus.key_on[0] = 1'b1;
        do_sample(32'h0, 5'd1, 170, 1'b0);
        do_sample(32'h0, 5'd1, 171, 1'b0);

        // All voices up to full scale at index 256, then to index 768.
        bus.key_on = '1;
        set_all_tunes(32'h4000_0000);
        do_sample(32'h0, 5'd10, 200, 1'b0);
        set_all_tunes(32'h0);
        for (int s = 1; s <= 16; s++) begin
            g0 = (32 + 16 * s > 255) ? 255 : 32 + 16 * s;
            go = (16 * s > 255) ? 255 : 16 * s;
            do_sample((s == 16) ? 32'h7FFF_FF00 : mix_out(AMP * (g0 + 9 * go)), 5'd10, 200 + s, 1'b0);
        end
        set_all_tunes(32'h8000_0000);
        do_sample(32'h7FFF_FF00, 5'd10, 220, 1'b0);
        set_all_tunes(32'h0);
        do_sample(32'h8000_0000, 5'd10, 221, 1'b0);

        // Backpressure: sample held stable for 20 cycles, extra request ignored.
        bus.sample_ready = 1'b0;
        exp_q.push_back('{out: 32'h8000_0000, act: 5'd10, tag: 16'd230});
        @(negedge clk); bus.sample_req = 1'b1;
        @(negedge clk); bus.sample_req = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1; n++;
            seen = bus.sample_valid;
        end
        check32("bp_valid_seen", 32'(seen), 32'd1);
        held = bus.sample_out;
        check32("bp_held_value", held, 32'h8000_0000);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            bus.sample_req = (c == 3);
            check32($sformatf("bp_stable_%0d", c), bus.sample_out, held);
            check32($sformatf("bp_valid_%0d", c), 32'(bus.sample_valid), 32'd1);
        end
        bus.sample_req = 1'b0;
        bus.sample_ready = 1'b1;
        @(posedge clk); #1;
        check32("bp_valid_drop", 32'(bus.sample_valid), 32'd0);
        check32("bp_busy_drop", 32'(bus.busy), 32'd0);
        repeat (20) @(posedge clk);

        // Reset while a full-scale sample is held.
        bus.sample_ready = 1'b0;
        @(negedge clk); bus.sample_req = 1'b1;
        @(negedge clk); bus.sample_req = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1; n++;
            seen = bus.sample_valid;
        end
        check32("hold_before_rst", bus.sample_out, 32'h8000_0000);
        rst_n = 1'b0;
        #1;
        check32("midrst_valid", 32'(bus.sample_valid), 32'd0);
        check32("midrst_out", bus.sample_out, 32'h0);
        check32("midrst_busy", 32'(bus.busy), 32'd0);
        check32("midrst_active", 32'(bus.active_voices), 32'd0);
        bus.key_on = '0;
        bus.sample_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        do_sample(32'h0, 5'd0, 240, 1'b0);

        repeat (5) @(posedge clk);
        check32("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
